// File: rtl/scrod_trg_handshake_pkg.sv
// Shared types and constants for the SCROD trigger handshake block.
// Channel state encoding, timer width and counter helpers.
package scrod_trg_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PULSE        = 3'd1,
        WAIT_ACK     = 3'd2,
        WAIT_RELEASE = 3'd3,
        HOLDOFF      = 3'd4
    } chan_state_t;

    localparam int          N_CH_DEFAULT = 12;
    localparam int          TMR_W        = 10;
    localparam logic [15:0] CNT16_MAX    = 16'hFFFF;

    // 16-bit add that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? CNT16_MAX : s[15:0];
    endfunction

endpackage

// File: rtl/scrod_trg_handshake_if.sv
// Trigger/link bus between the trigger decision, this block and the SCRODs.
// master drives trigger level, mask and link acks; slave returns pulses and BUSY.
interface scrod_trg_handshake_if
    import scrod_trg_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT
);

    logic [N_CH-1:0] TRG_IN;
    logic [N_CH-1:0] TRG_MASK;
    logic [N_CH-1:0] SCROD_ACK;
    logic [N_CH-1:0] SCROD_TRG;
    logic            BUSY;

    modport master (
        output TRG_IN,
        output TRG_MASK,
        output SCROD_ACK,
        input  SCROD_TRG,
        input  BUSY
    );

    modport slave (
        input  TRG_IN,
        input  TRG_MASK,
        input  SCROD_ACK,
        output SCROD_TRG,
        output BUSY
    );

endinterface

// File: rtl/scrod_trg_handshake_chan.sv
// One SCROD link: ack synchronizer, pulse/ack/release/holdoff FSM and timer.
// timeout_pulse is high for the single cycle in which the link gives up.
module scrod_trg_chan
    import scrod_trg_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1023,
    parameter int HOLD_CYC  = 8
) (
    input  logic CLK_42MHZ,
    input  logic TRG_CLR,
    input  logic start,
    input  logic ack_raw,
    output logic trg,
    output logic busy,
    output logic timeout_pulse
);

    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    chan_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             trg_q, trg_d;
    logic             ack_meta_q, ack_meta_d;
    logic             ack_s_q, ack_s_d;
    logic             tmo;

    // next state, timer and registered pulse output
    always_comb begin
        ack_meta_d = ack_raw;
        ack_s_d    = ack_meta_q;
        state_d    = state_q;
        timer_d    = timer_q;
        tmo        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PULSE;
                    timer_d = '0;
                end
            end
            PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = WAIT_ACK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            WAIT_ACK: begin
                if (ack_s_q) begin
                    state_d = WAIT_RELEASE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = HOLDOFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (!ack_s_q) begin
                    state_d = HOLDOFF;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = HOLDOFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            HOLDOFF: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        trg_d = (state_d == PULSE);
    end

    // channel registers; reset drops the pulse without waiting for a clock
    always_ff @(posedge CLK_42MHZ or posedge TRG_CLR) begin
        if (TRG_CLR) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            trg_q      <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            trg_q      <= trg_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
        end
    end

    assign trg           = trg_q;
    assign busy          = (state_q != IDLE);
    assign timeout_pulse = tmo;

endmodule

// File: rtl/scrod_trg_handshake.sv
// Trigger fan-out to SCROD links with ack tracking, BUSY veto and statistics.
// Edge detect and accept decision here; per-link handshakes in scrod_trg_chan.
module scrod_trg_handshake
    import scrod_trg_pkg::*;
#(
    parameter int N_CH      = N_CH_DEFAULT,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1023,
    parameter int HOLDOFF   = 8
) (
    input  logic                    CLK_42MHZ,
    input  logic                    TRG_CLR,
    scrod_trg_handshake_if.slave    bus,
    input  logic                    FLAG_CLR,
    output logic [N_CH-1:0]         TIMEOUT_FLAGS,
    output logic [15:0]             TIMEOUT_COUNT,
    output logic [31:0]             ACCEPT_COUNT,
    output logic [15:0]             REJECT_COUNT
);

    logic            trg_prev_q, trg_prev_d;
    logic            trg_any, trg_edge, accept, reject;
    logic [N_CH-1:0] start, ch_trg, ch_busy, ch_tmo;
    logic [N_CH-1:0] flags_q, flags_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic [15:0]     rej_cnt_q, rej_cnt_d;
    logic [31:0]     acc_cnt_q, acc_cnt_d;
    logic [15:0]     tmo_inc;

    assign trg_any  = |bus.TRG_IN;
    assign trg_edge = trg_any & ~trg_prev_q;
    assign accept   = trg_edge & ~bus.BUSY & (|bus.TRG_MASK);
    assign reject   = trg_edge & bus.BUSY;
    assign start    = {N_CH{accept}} & bus.TRG_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        scrod_trg_chan #(
            .PULSE_LEN (PULSE_LEN),
            .TIMEOUT   (TIMEOUT),
            .HOLD_CYC  (HOLDOFF)
        ) u_chan (
            .CLK_42MHZ     (CLK_42MHZ),
            .TRG_CLR       (TRG_CLR),
            .start         (start[i]),
            .ack_raw       (bus.SCROD_ACK[i]),
            .trg           (ch_trg[i]),
            .busy          (ch_busy[i]),
            .timeout_pulse (ch_tmo[i])
        );
    end

    assign bus.SCROD_TRG = ch_trg;
    assign bus.BUSY      = |ch_busy;

    // statistics; an event in the clearing cycle survives the clear
    always_comb begin
        trg_prev_d = trg_any;
        tmo_inc    = '0;
        for (int i = 0; i < N_CH; i++) begin
            tmo_inc = tmo_inc + 16'(ch_tmo[i]);
        end
        flags_d   = (FLAG_CLR ? '0 : flags_q) | ch_tmo;
        tmo_cnt_d = sat_add16(FLAG_CLR ? '0 : tmo_cnt_q, tmo_inc);
        rej_cnt_d = sat_add16(FLAG_CLR ? '0 : rej_cnt_q, 16'(reject));
        acc_cnt_d = (FLAG_CLR ? '0 : acc_cnt_q) + 32'(accept);
    end

    // edge register and status registers
    always_ff @(posedge CLK_42MHZ or posedge TRG_CLR) begin
        if (TRG_CLR) begin
            trg_prev_q <= 1'b0;
            flags_q    <= '0;
            tmo_cnt_q  <= '0;
            rej_cnt_q  <= '0;
            acc_cnt_q  <= '0;
        end else begin
            trg_prev_q <= trg_prev_d;
            flags_q    <= flags_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rej_cnt_q  <= rej_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign TIMEOUT_FLAGS = flags_q;
    assign TIMEOUT_COUNT = tmo_cnt_q;
    assign ACCEPT_COUNT  = acc_cnt_q;
    assign REJECT_COUNT  = rej_cnt_q;

endmodule

// File: tb/tb_scrod_trg_handshake.sv
// Bench for scrod_trg_handshake: directed scenarios plus random traffic,
// every cycle compared against a timestamp-based model of the link protocol.
module tb_scrod_trg_handshake;

    localparam int N  = 12;
    localparam int P  = 4;
    localparam int TO = 1023;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flag_clr;
    logic [N-1:0]  tflags;
    logic [15:0]   tcnt;
    logic [15:0]   rcnt;
    logic [31:0]   acnt;

    scrod_trg_handshake_if #(.N_CH(N)) bus ();

    scrod_trg_handshake #(
        .N_CH      (N),
        .PULSE_LEN (P),
        .TIMEOUT   (TO),
        .HOLDOFF   (H)
    ) dut (
        .CLK_42MHZ     (clk),
        .TRG_CLR       (rst),
        .bus           (bus),
        .FLAG_CLR      (flag_clr),
        .TIMEOUT_FLAGS (tflags),
        .TIMEOUT_COUNT (tcnt),
        .ACCEPT_COUNT  (acnt),
        .REJECT_COUNT  (rcnt)
    );

    always #12 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // model: each link remembers when it was accepted, when its ack was
    // seen and when its holdoff began, as absolute clock-edge numbers
    int          now;
    bit          m_act  [N];
    int          m_acc  [N];
    int          m_rel  [N];
    int          m_hold [N];
    logic [N-1:0] h1, h2;
    bit          m_prev;
    logic [N-1:0] m_flags;
    int          m_tcnt, m_rcnt;
    logic [31:0] m_acnt;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s edge=%0d got=%h want=%h", nm, now, act, exp);
        end
    endtask

    task automatic model_reset();
        now = 0;
        h1 = '0;
        h2 = '0;
        m_prev = 1'b0;
        m_flags = '0;
        m_tcnt = 0;
        m_rcnt = 0;
        m_acnt = '0;
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0;
            m_acc[i] = -1;
            m_rel[i] = -1;
            m_hold[i] = -1;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] acks, tbits;
        bit busy_before, edge_seen, acc, rej;
        int ntmo, j;
        acks = h2;
        tbits = '0;
        ntmo = 0;
        busy_before = 1'b0;
        for (int i = 0; i < N; i++) busy_before |= m_act[i];
        now++;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_hold[i] >= 0) begin
                    if (now == m_hold[i] + H) m_act[i] = 1'b0;
                end else if (m_rel[i] >= 0) begin
                    j = now - m_rel[i] - 1;
                    if (!acks[i]) begin
                        m_hold[i] = now;
                    end else if (j == TO) begin
                        tbits[i] = 1'b1;
                        ntmo++;
                        m_hold[i] = now;
                    end
                end else if (now > m_acc[i] + P) begin
                    j = now - m_acc[i] - P - 1;
                    if (acks[i]) begin
                        m_rel[i] = now;
                    end else if (j == TO) begin
                        tbits[i] = 1'b1;
                        ntmo++;
                        m_hold[i] = now;
                    end
                end
            end
        end
        edge_seen = (bus.TRG_IN != '0) && !m_prev;
        m_prev = (bus.TRG_IN != '0);
        acc = edge_seen && !busy_before && (bus.TRG_MASK != '0);
        rej = edge_seen && busy_before;
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                if (bus.TRG_MASK[i]) begin
                    m_act[i] = 1'b1;
                    m_acc[i] = now;
                    m_rel[i] = -1;
                    m_hold[i] = -1;
                end
            end
        end
        if (flag_clr) begin
            m_flags = '0;
            m_tcnt = 0;
            m_rcnt = 0;
            m_acnt = '0;
        end
        m_flags |= tbits;
        m_tcnt = (m_tcnt + ntmo > 65535) ? 65535 : m_tcnt + ntmo;
        m_rcnt = (m_rcnt + int'(rej) > 65535) ? 65535 : m_rcnt + int'(rej);
        m_acnt = m_acnt + 32'(acc);
        h2 = h1;
        h1 = bus.SCROD_ACK;
    endtask

    task automatic compare();
        logic [N-1:0] et;
        bit eb;
        et = '0;
        eb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                eb = 1'b1;
                if (m_hold[i] < 0 && m_rel[i] < 0 && now < m_acc[i] + P)
                    et[i] = 1'b1;
            end
        end
        chk("SCROD_TRG", 32'(bus.SCROD_TRG), 32'(et));
        chk("BUSY", 32'(bus.BUSY), 32'(eb));
        chk("TIMEOUT_FLAGS", 32'(tflags), 32'(m_flags));
        chk("TIMEOUT_COUNT", 32'(tcnt), 32'(m_tcnt));
        chk("ACCEPT_COUNT", acnt, m_acnt);
        chk("REJECT_COUNT", 32'(rcnt), 32'(m_rcnt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flag_clr = 1'b0;
        bus.TRG_IN = '0;
        bus.TRG_MASK = '0;
        bus.SCROD_ACK = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_trg", 32'(bus.SCROD_TRG), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_cnt", acnt | 32'(tcnt) | 32'(rcnt) | 32'(tflags), 32'h0);
    endtask

    int rises;
    logic prev0;
    logic [N-1:0] seen;
    bit trg_lvl;
    int mode [N];

    initial begin
        // all links ack three cycles into the pulse, release two later
        do_reset();
        bus.TRG_MASK = 12'hFFF;
        bus.TRG_IN = 12'hFFF;
        step();
        chk("t1_trg_first", 32'(bus.SCROD_TRG), 32'hFFF);
        bus.TRG_IN = '0;
        for (int k = 1; k <= 30; k++) begin
            bus.SCROD_ACK = (k == 3 || k == 4) ? 12'hFFF : 12'h000;
            step();
            if (k == 3) chk("t1_trg_last", 32'(bus.SCROD_TRG), 32'hFFF);
            if (k == 4) chk("t1_trg_end", 32'(bus.SCROD_TRG), 32'h0);
        end
        chk("t1_busy", 32'(bus.BUSY), 32'h0);
        chk("t1_acc", acnt, 32'd1);
        chk("t1_flags", 32'(tflags), 32'h0);

        // link 2 silent, second trigger edge while busy
        do_reset();
        bus.TRG_MASK = 12'h00F;
        bus.TRG_IN = 12'hFFF;
        seen = '0;
        rises = 0;
        prev0 = 1'b0;
        for (int k = 0; k <= 1100; k++) begin
            bus.SCROD_ACK = (k >= 3 && k <= 6) ? 12'h00B : 12'h000;
            if (k == 10) bus.TRG_IN = '0;
            if (k == 12) bus.TRG_IN = 12'hFFF;
            step();
            seen |= bus.SCROD_TRG;
            if (bus.SCROD_TRG[0] && !prev0) rises++;
            prev0 = bus.SCROD_TRG[0];
        end
        chk("t2_flags", 32'(tflags), 32'h004);
        chk("t2_tcnt", 32'(tcnt), 32'd1);
        chk("t2_quiet", 32'(seen & 12'hFF0), 32'h0);
        chk("t3_rej", 32'(rcnt), 32'd1);
        chk("t3_acc", acnt, 32'd1);
        chk("t3_rises", 32'(rises), 32'd1);

        // ack already high: straight to release, then release timeout
        do_reset();
        bus.SCROD_ACK = 12'h001;
        bus.TRG_MASK = 12'h001;
        step();
        step();
        step();
        bus.TRG_IN = 12'hFFF;
        for (int k = 0; k <= 1040; k++) begin
            step();
            if (k == 1028) chk("t4_flag_pre", 32'(tflags), 32'h0);
            if (k == 1029) chk("t4_flag_set", 32'(tflags), 32'h001);
        end
        chk("t4_tcnt", 32'(tcnt), 32'd1);

        // clear in the very cycle two links time out
        do_reset();
        bus.TRG_MASK = 12'h003;
        bus.TRG_IN = 12'hFFF;
        for (int k = 0; k <= 1027; k++) step();
        chk("t5_flag_pre", 32'(tflags), 32'h0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("t5_flags", 32'(tflags), 32'h003);
        chk("t5_tcnt", 32'(tcnt), 32'd2);
        chk("t5_acc", acnt, 32'd0);

        // asynchronous reset in the middle of a pulse
        do_reset();
        bus.TRG_MASK = 12'hFFF;
        bus.TRG_IN = 12'hFFF;
        step();
        step();
        chk("t6_pre", 32'(bus.SCROD_TRG), 32'hFFF);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_trg", 32'(bus.SCROD_TRG), 32'h0);
        chk("t6_busy", 32'(bus.BUSY), 32'h0);
        chk("t6_acc", acnt, 32'd0);

        // random traffic
        do_reset();
        trg_lvl = 1'b0;
        for (int i = 0; i < N; i++) mode[i] = 0;
        for (int c = 0; c < 25000; c++) begin
            if (c % 3000 == 0) begin
                for (int i = 0; i < N; i++) begin
                    mode[i] = $urandom_range(5);
                    if (mode[i] > 2) mode[i] = 0;
                end
            end
            if ($urandom_range(7) == 0) trg_lvl = ~trg_lvl;
            if (!trg_lvl) bus.TRG_IN = '0;
            else if ($urandom_range(3) == 0) bus.TRG_IN = N'($urandom_range(1, 4095));
            else bus.TRG_IN = '1;
            if ($urandom_range(63) == 0) begin
                bus.TRG_MASK = N'($urandom);
                if ($urandom_range(7) == 0) bus.TRG_MASK = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (mode[i] == 1) bus.SCROD_ACK[i] = 1'b0;
                else if (mode[i] == 2) bus.SCROD_ACK[i] = 1'b1;
                else if ($urandom_range(5) == 0) bus.SCROD_ACK[i] = ~bus.SCROD_ACK[i];
            end
            flag_clr = ($urandom_range(199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
